load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 70 +++++++
 rtl/lsu_load_format.sv | 51 +++++
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : codes (package)
// Description : Shared types for the load/store unit: the core memory opcodes,
//               access sizes, the LSU state encoding and the default bus
//               timeout, plus small opcode decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package codes;

   // Memory opcodes, encoded as the primary opcode field of the core ISA.
   typedef enum logic [5:0] {
      OP_LB  = 6'h20,
      OP_LH  = 6'h21,
      OP_LW  = 6'h23,
      OP_LBU = 6'h24,
      OP_LHU = 6'h25,
      OP_SB  = 6'h28,
      OP_SH  = 6'h29,
      OP_SW  = 6'h2B
   } opcode_t;

   // SZ_NONE marks an opcode the unit does not support.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_NONE = 2'd3
   } size_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } lsu_state_t;

   localparam int unsigned BUS_TIMEOUT_DEFAULT = 255;

   function automatic size_t op_size(input opcode_t op);
      size_t sz;
      case (op)
         OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
         OP_LW, OP_SW:         sz = SZ_WORD;
         default:              sz = SZ_NONE;
      endcase
      return sz;
   endfunction

   function automatic logic op_is_load(input opcode_t op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
             (op == OP_LHU) || (op == OP_LW);
   endfunction

   function automatic logic op_is_store(input opcode_t op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic misaligned(input size_t sz, input logic [1:0] off);
      logic bad;
      case (sz)
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = |off;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_format.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_format
// Description : Combinational load result formatting. Selects the big-endian
//               byte/half lane addressed by the low address bits and sign- or
//               zero-extends it; words pass through. Non-loads give zero.
// Ports       : op_i       - registered opcode of the transaction
//               offset_i   - byte offset within the word (addr[1:0])
//               readdata_i - word captured from the bus
//               data_o     - formatted 32-bit load result
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_format
   import codes::*;
(
   input  opcode_t     op_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] readdata_i,
   output logic [31:0] data_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Offset 0 is the most significant lane.
   always_comb begin
      w_byte = 8'h00;
      case (offset_i)
         2'd0:    w_byte = readdata_i[31:24];
         2'd1:    w_byte = readdata_i[23:16];
         2'd2:    w_byte = readdata_i[15:8];
         default: w_byte = readdata_i[7:0];
      endcase
   end

   assign w_half = offset_i[1] ? readdata_i[15:0] : readdata_i[31:16];

   always_comb begin
      data_o = 32'h0;
      case (op_i)
         OP_LB:   data_o = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  data_o = {24'h0, w_byte};
         OP_LH:   data_o = {{16{w_half[15]}}, w_half};
         OP_LHU:  data_o = {16'h0, w_half};
         OP_LW:   data_o = readdata_i;
         default: data_o = 32'h0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit bridging core memory
//               requests to a big-endian Avalon-MM master, with alignment
//               checking and an optional waitrequest timeout.
// Ports       : clk, reset_ni (sync, active-low)
//               req_valid_i/req_ready_o, op_i, addr_i, store_data_i - request
//               done_o, load_data_o, addr_error_o, bus_error_o      - response
//               avm_*                                                - Avalon-MM
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
   import codes::*;
#(
   parameter int unsigned BUS_TIMEOUT = BUS_TIMEOUT_DEFAULT
)
(
   input  logic        clk,
   input  logic        reset_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  opcode_t     op_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] store_data_i,
   output logic        done_o,
   output logic [31:0] load_data_o,
   output logic        addr_error_o,
   output logic        bus_error_o,
   output logic [31:0] avm_address_o,
   output logic        avm_read_o,
   output logic        avm_write_o,
   output logic [31:0] avm_writedata_o,
   output logic [3:0]  avm_byteenable_o,
   input  logic        avm_waitrequest_i,
   input  logic [31:0] avm_readdata_i
);

   localparam int unsigned c_cnt_w = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
   // Value of the stall counter on the stall that exhausts the budget.
   localparam logic [c_cnt_w-1:0] c_last_stall = c_cnt_w'(BUS_TIMEOUT - 1);

   lsu_state_t         r_state;
   lsu_state_t         w_state_next;
   opcode_t            r_op;
   logic [31:0]        r_addr;
   logic [31:0]        r_wdata;
   logic [3:0]         r_be;
   logic               r_read;
   logic               r_write;
   logic [31:0]        r_rdata;
   logic               r_addr_err;
   logic               r_bus_err;
   logic [c_cnt_w-1:0] r_count;

   logic               w_accept;
   logic               w_bus_done;
   logic               w_timeout;
   size_t              w_req_size;
   logic               w_req_bad;
   logic [31:0]        w_req_wdata;
   logic [3:0]         w_req_be;
   logic [31:0]        w_fmt_data;

   // ---------------------------------------------------------------- request
   assign w_req_size = op_size(op_i);
   assign w_req_bad  = (w_req_size == SZ_NONE) || misaligned(w_req_size, addr_i[1:0]);

   always_comb begin
      w_req_wdata = store_data_i;
      w_req_be    = 4'b0000;
      case (w_req_size)
         SZ_BYTE: begin
            w_req_wdata = {4{store_data_i[7:0]}};
            w_req_be    = 4'b1000 >> addr_i[1:0];
         end
         SZ_HALF: begin
            w_req_wdata = {2{store_data_i[15:0]}};
            w_req_be    = addr_i[1] ? 4'b0011 : 4'b1100;
         end
         SZ_WORD: begin
            w_req_wdata = store_data_i;
            w_req_be    = 4'b1111;
         end
         default: begin
            w_req_wdata = store_data_i;
            w_req_be    = 4'b0000;
         end
      endcase
   end

   // -------------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (!reset_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_bus_done   = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid_i) begin
               w_accept     = 1'b1;
               w_state_next = w_req_bad ? RESP : BUS;
            end
         end
         BUS: begin
            if (!avm_waitrequest_i) begin
               w_bus_done   = 1'b1;
               w_state_next = RESP;
            end else if ((BUS_TIMEOUT != 0) && (r_count == c_last_stall)) begin
               w_timeout    = 1'b1;
               w_state_next = RESP;
            end
         end
         RESP: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------- datapath
   // Bus-side registers only change on accept or when the bus phase ends, so
   // the Avalon outputs stay stable across waitrequest stalls.
   always_ff @(posedge clk) begin
      if (!reset_ni) begin
         r_op       <= OP_LW;
         r_addr     <= 32'h0;
         r_wdata    <= 32'h0;
         r_be       <= 4'b0000;
         r_read     <= 1'b0;
         r_write    <= 1'b0;
         r_rdata    <= 32'h0;
         r_addr_err <= 1'b0;
         r_bus_err  <= 1'b0;
         r_count    <= '0;
      end else begin
         if (w_accept) begin
            r_op       <= op_i;
            r_addr     <= addr_i;
            r_wdata    <= w_req_wdata;
            r_be       <= w_req_be;
            r_read     <= !w_req_bad && op_is_load(op_i);
            r_write    <= !w_req_bad && op_is_store(op_i);
            r_rdata    <= 32'h0;
            r_addr_err <= w_req_bad;
            r_bus_err  <= 1'b0;
            r_count    <= '0;
         end
         if (r_state == BUS) begin
            if (avm_waitrequest_i) begin
               r_count <= r_count + 1'b1;
            end
            if (w_bus_done && r_read) begin
               r_rdata <= avm_readdata_i;
            end
            if (w_bus_done || w_timeout) begin
               r_read  <= 1'b0;
               r_write <= 1'b0;
            end
            if (w_timeout) begin
               r_bus_err <= 1'b1;
            end
         end
      end
   end

   lsu_load_format u_load_format (
      .op_i       (r_op),
      .offset_i   (r_addr[1:0]),
      .readdata_i (r_rdata),
      .data_o     (w_fmt_data)
   );

   // ---------------------------------------------------------------- outputs
   assign req_ready_o      = (r_state == IDLE);
   assign done_o           = (r_state == RESP);
   assign addr_error_o     = done_o && r_addr_err;
   assign bus_error_o      = done_o && r_bus_err;
   assign load_data_o      = (done_o && !r_addr_err && !r_bus_err) ? w_fmt_data : 32'h0;
   assign avm_address_o    = {r_addr[31:2], 2'b00};
   assign avm_read_o       = r_read;
   assign avm_write_o      = r_write;
   assign avm_writedata_o  = r_wdata;
   assign avm_byteenable_o = r_be;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit: a table of directed
//               single-transaction vectors plus hand-written stall, timeout
//               and reset-abort sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
   import codes::*;

   logic        clk = 1'b0;
   logic        reset_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   opcode_t     op_i;
   logic [31:0] addr_i;
   logic [31:0] store_data_i;
   logic        done_o;
   logic [31:0] load_data_o;
   logic        addr_error_o;
   logic        bus_error_o;
   logic [31:0] avm_address_o;
   logic        avm_read_o;
   logic        avm_write_o;
   logic [31:0] avm_writedata_o;
   logic [3:0]  avm_byteenable_o;
   logic        avm_waitrequest_i;
   logic [31:0] avm_readdata_i;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   load_store_unit #(.BUS_TIMEOUT(4)) dut (
      .clk               (clk),
      .reset_ni          (reset_ni),
      .req_valid_i       (req_valid_i),
      .req_ready_o       (req_ready_o),
      .op_i              (op_i),
      .addr_i            (addr_i),
      .store_data_i      (store_data_i),
      .done_o            (done_o),
      .load_data_o       (load_data_o),
      .addr_error_o      (addr_error_o),
      .bus_error_o       (bus_error_o),
      .avm_address_o     (avm_address_o),
      .avm_read_o        (avm_read_o),
      .avm_write_o       (avm_write_o),
      .avm_writedata_o   (avm_writedata_o),
      .avm_byteenable_o  (avm_byteenable_o),
      .avm_waitrequest_i (avm_waitrequest_i),
      .avm_readdata_i    (avm_readdata_i)
   );

   typedef struct {
      opcode_t     op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic [31:0] exp_ld;
      logic        exp_err;
   } vec_t;

   localparam int c_nvec = 14;
   vec_t vecs[c_nvec];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Present one request; returns #1 after the accept edge (cycle N+1).
   task automatic issue(input opcode_t op, input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      req_valid_i  = 1'b1;
      op_i         = op;
      addr_i       = addr;
      store_data_i = wd;
      next_cycle();
      req_valid_i  = 1'b0;
   endtask

   task automatic apply_vec(input vec_t v);
      logic is_st;
      is_st = (v.op == OP_SB) || (v.op == OP_SH) || (v.op == OP_SW);
      avm_readdata_i    = v.rdata;
      avm_waitrequest_i = 1'b0;
      issue(v.op, v.addr, v.wdata);
      if (v.exp_err) begin
         chk("err_done",     {31'h0, done_o},       32'h1);
         chk("err_flag",     {31'h0, addr_error_o}, 32'h1);
         chk("err_no_read",  {31'h0, avm_read_o},   32'h0);
         chk("err_no_write", {31'h0, avm_write_o},  32'h0);
         chk("err_ld_zero",  load_data_o,           32'h0);
      end else begin
         chk("bus_read",  {31'h0, avm_read_o},  {31'h0, !is_st});
         chk("bus_write", {31'h0, avm_write_o}, {31'h0, is_st});
         chk("bus_addr",  avm_address_o, v.addr & 32'hFFFF_FFFC);
         chk("bus_be",    {28'h0, avm_byteenable_o}, {28'h0, v.exp_be});
         if (is_st) chk("bus_wdata", avm_writedata_o, v.exp_wd);
         chk("bus_no_done", {31'h0, done_o}, 32'h0);
         next_cycle();
         chk("done",       {31'h0, done_o},       32'h1);
         chk("load_data",  load_data_o,           v.exp_ld);
         chk("no_addrerr", {31'h0, addr_error_o}, 32'h0);
         chk("no_buserr",  {31'h0, bus_error_o},  32'h0);
         chk("rw_dropped", {30'h0, avm_read_o, avm_write_o}, 32'h0);
      end
      next_cycle();
      chk("done_once",   {31'h0, done_o},      32'h0);
      chk("ready_again", {31'h0, req_ready_o}, 32'h1);
   endtask

   initial begin
      vecs[0]  = '{OP_LW,  32'h1000, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[1]  = '{OP_LB,  32'h1001, 32'h0,        32'h1280FF34, 4'b0100, 32'h0,        32'hFFFFFF80, 1'b0};
      vecs[2]  = '{OP_LBU, 32'h1001, 32'h0,        32'h1280FF34, 4'b0100, 32'h0,        32'h00000080, 1'b0};
      vecs[3]  = '{OP_LH,  32'h1002, 32'h0,        32'h1280FF34, 4'b0011, 32'h0,        32'hFFFFFF34, 1'b0};
      vecs[4]  = '{OP_LHU, 32'h1000, 32'h0,        32'h1280FF34, 4'b1100, 32'h0,        32'h00001280, 1'b0};
      vecs[5]  = '{OP_LB,  32'h1003, 32'h0,        32'h1280FF34, 4'b0001, 32'h0,        32'h00000034, 1'b0};
      vecs[6]  = '{OP_SB,  32'h2000, 32'h000000A5, 32'h0,        4'b1000, 32'hA5A5A5A5, 32'h0,        1'b0};
      vecs[7]  = '{OP_SH,  32'h2000, 32'hCAFE1234, 32'h0,        4'b1100, 32'h12341234, 32'h0,        1'b0};
      vecs[8]  = '{OP_SW,  32'h2004, 32'hCAFE1234, 32'h0,        4'b1111, 32'hCAFE1234, 32'h0,        1'b0};
      vecs[9]  = '{OP_LW,  32'h1002, 32'h0,        32'hDEADBEEF, 4'b0000, 32'h0,        32'h0,        1'b1};
      vecs[10] = '{OP_SH,  32'h2001, 32'h1234,     32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
      vecs[11] = '{OP_SW,  32'h2002, 32'h1234,     32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
      vecs[12] = '{OP_LH,  32'h1001, 32'h0,        32'h1280FF34, 4'b0000, 32'h0,        32'h0,        1'b1};
      vecs[13] = '{opcode_t'(6'h00), 32'h1000, 32'h0, 32'h1, 4'b0000, 32'h0,        32'h0,        1'b1};

      reset_ni          = 1'b0;
      req_valid_i       = 1'b0;
      op_i              = OP_LW;
      addr_i            = 32'h0;
      store_data_i      = 32'h0;
      avm_waitrequest_i = 1'b0;
      avm_readdata_i    = 32'h0;
      next_cycle();
      next_cycle();
      chk("rst_ready", {31'h0, req_ready_o}, 32'h1);
      chk("rst_done",  {31'h0, done_o},      32'h0);
      chk("rst_rw",    {30'h0, avm_read_o, avm_write_o}, 32'h0);
      chk("rst_be",    {28'h0, avm_byteenable_o}, 32'h0);
      chk("rst_ld",    load_data_o, 32'h0);
      chk("rst_errs",  {30'h0, addr_error_o, bus_error_o}, 32'h0);
      @(negedge clk);
      reset_ni = 1'b1;
      next_cycle();

      for (int i = 0; i < c_nvec; i++) apply_vec(vecs[i]);

      // SH with three stalled cycles: outputs held, done five cycles after accept.
      avm_waitrequest_i = 1'b1;
      issue(OP_SH, 32'h2002, 32'hCAFE1234);
      for (int k = 0; k < 3; k++) begin
         chk("stall_write", {31'h0, avm_write_o}, 32'h1);
         chk("stall_wdata", avm_writedata_o, 32'h12341234);
         chk("stall_be",    {28'h0, avm_byteenable_o}, 32'h3);
         chk("stall_addr",  avm_address_o, 32'h2000);
         chk("stall_done",  {31'h0, done_o}, 32'h0);
         next_cycle();
      end
      avm_waitrequest_i = 1'b0;
      chk("stall_last_write", {31'h0, avm_write_o}, 32'h1);
      chk("stall_last_done",  {31'h0, done_o}, 32'h0);
      next_cycle();
      chk("stall_done5",   {31'h0, done_o},      32'h1);
      chk("stall_wdrop",   {31'h0, avm_write_o}, 32'h0);
      chk("stall_nobuserr",{31'h0, bus_error_o}, 32'h0);
      next_cycle();
      chk("stall_ready",   {31'h0, req_ready_o}, 32'h1);

      // Timeout: waitrequest stuck high, read held four cycles then aborted.
      avm_waitrequest_i = 1'b1;
      avm_readdata_i    = 32'h55555555;
      issue(OP_LW, 32'h3000, 32'h0);
      for (int k = 0; k < 4; k++) begin
         chk("to_read", {31'h0, avm_read_o}, 32'h1);
         chk("to_done", {31'h0, done_o},     32'h0);
         next_cycle();
      end
      chk("to_read_drop", {31'h0, avm_read_o},  32'h0);
      chk("to_done1",     {31'h0, done_o},      32'h1);
      chk("to_buserr",    {31'h0, bus_error_o}, 32'h1);
      chk("to_noaddrerr", {31'h0, addr_error_o},32'h0);
      chk("to_ld_zero",   load_data_o,          32'h0);
      avm_waitrequest_i = 1'b0;
      next_cycle();
      chk("to_done_once", {31'h0, done_o},      32'h0);
      chk("to_buserr_once",{31'h0, bus_error_o},32'h0);

      // Reset during a stalled SW: write drops, no completion.
      avm_waitrequest_i = 1'b1;
      issue(OP_SW, 32'h2008, 32'h01020304);
      chk("rs_write", {31'h0, avm_write_o}, 32'h1);
      @(negedge clk);
      reset_ni = 1'b0;
      next_cycle();
      chk("rs_wdrop", {31'h0, avm_write_o}, 32'h0);
      chk("rs_nodone",{31'h0, done_o},      32'h0);
      chk("rs_noerr", {30'h0, addr_error_o, bus_error_o}, 32'h0);
      chk("rs_ready", {31'h0, req_ready_o}, 32'h1);
      @(negedge clk);
      reset_ni          = 1'b1;
      avm_waitrequest_i = 1'b0;
      next_cycle();
      chk("rs_ready2", {31'h0, req_ready_o}, 32'h1);
      chk("rs_nodone2",{31'h0, done_o},      32'h0);

      apply_vec(vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
